multi_cycle_ctrl: RTL and testbench



---
 rtl/cpu_ctrl_pkg.sv | 57 +++++
 rtl/alu_ctrl_dec.sv | 33 +++
 rtl/multi_cycle_ctrl.sv | 154 +++++++++++++++
 tb/tb_multi_cycle_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV32 control unit.
// Holds the FSM state enum, opcode constants, ALU control codes and mux select codes.
package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        EXEC_R,
        EXEC_I,
        ALU_WB,
        MEM_ADDR,
        MEM_RD,
        LOAD_WB,
        MEM_WR,
        BRANCH,
        HALT
    } state_t;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_SLL = 4'b0100;
    localparam logic [3:0] ALU_SRL = 4'b0101;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SRA = 4'b1101;

    localparam logic [1:0] SRC_A_PC     = 2'd0;
    localparam logic [1:0] SRC_A_OLD_PC = 2'd1;
    localparam logic [1:0] SRC_A_RS1    = 2'd2;

    localparam logic [1:0] SRC_B_RS2    = 2'd0;
    localparam logic [1:0] SRC_B_FOUR   = 2'd1;
    localparam logic [1:0] SRC_B_IMM    = 2'd2;
    localparam logic [1:0] SRC_B_IMM_BR = 2'd3;

    // Branch condition from rs1 - rs2 flags; signed overflow is deliberately ignored.
    function automatic logic branch_taken(input logic [2:0] funct3,
                                          input logic       zero,
                                          input logic       sign);
        case (funct3)
            3'b000:  return zero;
            3'b001:  return !zero;
            3'b100:  return sign;
            3'b101:  return !sign;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_ctrl_dec.sv
// Combinational ALU operation select from FSM state and instruction function fields.
// Anything outside the execute/branch states gets ADD.
module alu_ctrl_dec
    import cpu_ctrl_pkg::*;
(
    input  state_t     state,
    input  logic       funct7_b5,
    input  logic [2:0] funct3,
    output logic [3:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (state)
            EXEC_R, EXEC_I: begin
                case (funct3)
                    // Immediate forms have no SUB, so bit 30 belongs to the immediate there.
                    3'b000: alu_control = (state == EXEC_R && funct7_b5) ? ALU_SUB : ALU_ADD;
                    3'b001: alu_control = ALU_SLL;
                    3'b010: alu_control = ALU_SLT;
                    3'b100: alu_control = ALU_XOR;
                    3'b101: alu_control = funct7_b5 ? ALU_SRA : ALU_SRL;
                    3'b110: alu_control = ALU_OR;
                    3'b111: alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            BRANCH:  alu_control = ALU_SUB;
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle RV32 control FSM: sequences fetch, decode, execute, memory and writeback
// for the shared datapath, and counts retired instructions.
module multi_cycle_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset_b,
    input  logic [31:0]          ir,
    input  logic                 alu_zero,
    input  logic                 alu_sign,
    input  logic                 mem_ready,
    output logic                 pc_write,
    output logic                 pc_src,
    output logic                 old_pc_write,
    output logic                 ir_write,
    output logic                 iord,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 mem_to_reg,
    output logic                 reg_write,
    output logic [1:0]           alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [3:0]           alu_control,
    output logic                 inst_retired,
    output logic [CNT_WIDTH-1:0] retire_count,
    output logic                 halted
);

    state_t     state;
    state_t     state_nxt;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_b5;
    logic       unused_ir_bits;

    assign opcode         = ir[6:0];
    assign funct3         = ir[14:12];
    assign funct7_b5      = ir[30];
    assign unused_ir_bits = ^{ir[31], ir[29:15], ir[11:7]};

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) state <= FETCH;
        else          state <= state_nxt;
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b)          retire_count <= '0;
        else if (inst_retired) retire_count <= retire_count + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end

    alu_ctrl_dec u_alu_ctrl_dec (
        .state       (state),
        .funct7_b5   (funct7_b5),
        .funct3      (funct3),
        .alu_control (alu_control)
    );

    always_comb begin
        state_nxt    = state;
        pc_write     = 1'b0;
        pc_src       = 1'b0;
        old_pc_write = 1'b0;
        ir_write     = 1'b0;
        iord         = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        mem_to_reg   = 1'b0;
        reg_write    = 1'b0;
        alu_src_a    = SRC_A_PC;
        alu_src_b    = SRC_B_RS2;
        inst_retired = 1'b0;
        halted       = 1'b0;

        case (state)
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRC_B_FOUR;
                if (mem_ready) begin
                    ir_write     = 1'b1;
                    old_pc_write = 1'b1;
                    pc_write     = 1'b1;
                    state_nxt    = DECODE;
                end
            end
            DECODE: begin
                // Branch target is precomputed here so BRANCH only has to compare.
                alu_src_a = SRC_A_OLD_PC;
                alu_src_b = SRC_B_IMM_BR;
                case (opcode)
                    OP_R:         state_nxt = EXEC_R;
                    OP_I:         state_nxt = EXEC_I;
                    OP_LD, OP_ST: state_nxt = MEM_ADDR;
                    OP_BR:        state_nxt = BRANCH;
                    default:      state_nxt = HALT;
                endcase
            end
            EXEC_R: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_RS2;
                state_nxt = ALU_WB;
            end
            EXEC_I: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_IMM;
                state_nxt = ALU_WB;
            end
            ALU_WB: begin
                reg_write    = 1'b1;
                inst_retired = 1'b1;
                state_nxt    = FETCH;
            end
            MEM_ADDR: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_IMM;
                state_nxt = (opcode == OP_ST) ? MEM_WR : MEM_RD;
            end
            MEM_RD: begin
                iord     = 1'b1;
                mem_read = 1'b1;
                if (mem_ready) state_nxt = LOAD_WB;
            end
            LOAD_WB: begin
                reg_write    = 1'b1;
                mem_to_reg   = 1'b1;
                inst_retired = 1'b1;
                state_nxt    = FETCH;
            end
            MEM_WR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
                if (mem_ready) begin
                    inst_retired = 1'b1;
                    state_nxt    = FETCH;
                end
            end
            BRANCH: begin
                alu_src_a    = SRC_A_RS1;
                alu_src_b    = SRC_B_RS2;
                pc_src       = 1'b1;
                pc_write     = branch_taken(funct3, alu_zero, alu_sign);
                inst_retired = 1'b1;
                state_nxt    = FETCH;
            end
            HALT: begin
                halted    = 1'b1;
                state_nxt = HALT;
            end
            default: state_nxt = FETCH;
        endcase
    end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Scoreboard bench for multi_cycle_ctrl: stimulus pushes per-instruction expectations,
// a monitor accumulates per-cycle activity and checks it on every retirement.
module tb_multi_cycle_ctrl;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset_b = 1'b0;
    logic [31:0]   ir = 32'h0;
    logic          alu_zero = 1'b0;
    logic          alu_sign = 1'b0;
    logic          mem_ready = 1'b0;
    logic          pc_write, pc_src, old_pc_write, ir_write, iord;
    logic          mem_read, mem_write, mem_to_reg, reg_write;
    logic [1:0]    alu_src_a, alu_src_b;
    logic [3:0]    alu_control;
    logic          inst_retired, halted;
    logic [CW-1:0] retire_count;

    multi_cycle_ctrl #(.CNT_WIDTH(CW)) dut (
        .clk(clk), .reset_b(reset_b), .ir(ir), .alu_zero(alu_zero), .alu_sign(alu_sign),
        .mem_ready(mem_ready), .pc_write(pc_write), .pc_src(pc_src),
        .old_pc_write(old_pc_write), .ir_write(ir_write), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_control(alu_control), .inst_retired(inst_retired),
        .retire_count(retire_count), .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] cycles;
        logic [31:0] regw;
        logic        m2r;
        logic [31:0] memw;
        logic [31:0] pcw;
        logic [31:0] pcw_src1;
        logic [3:0]  aluc;
        logic [31:0] cnt;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   model_cnt = 0;
    int   wt[2];
    int   acc = 0;
    int   wcnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference ALU operation, straight from the instruction-set rules.
    function automatic logic [3:0] alu_ref(input logic [2:0] f3, input logic b5, input bit is_r);
        case (f3)
            3'd0:    return (is_r && b5) ? 4'b0110 : 4'b0010;
            3'd1:    return 4'b0100;
            3'd2:    return 4'b0111;
            3'd4:    return 4'b0011;
            3'd5:    return b5 ? 4'b1101 : 4'b0101;
            3'd6:    return 4'b0001;
            3'd7:    return 4'b0000;
            default: return 4'b0010;
        endcase
    endfunction

    function automatic exp_t model(input logic [31:0] i, input bit z, input bit s,
                                   input int fw, input int mw);
        exp_t e;
        logic [2:0] f3;
        bit tk;
        e = '0;
        f3 = i[14:12];
        e.pcw = 1;
        case (i[6:0])
            7'b0110011: begin e.cycles = 4 + fw; e.regw = 1; e.aluc = alu_ref(f3, i[30], 1); end
            7'b0010011: begin e.cycles = 4 + fw; e.regw = 1; e.aluc = alu_ref(f3, i[30], 0); end
            7'b0000011: begin e.cycles = 5 + fw + mw; e.regw = 1; e.m2r = 1; e.aluc = 4'b0010; end
            7'b0100011: begin e.cycles = 4 + fw + mw; e.memw = mw + 1; e.aluc = 4'b0010; end
            default: begin
                tk = (f3 == 0 && z) || (f3 == 1 && !z) || (f3 == 4 && s) || (f3 == 5 && !s);
                e.cycles = 3 + fw; e.aluc = 4'b0110;
                e.pcw = 1 + tk; e.pcw_src1 = tk;
            end
        endcase
        return e;
    endfunction

    // Behaves as the unified memory: each access completes after its planned wait count.
    task automatic drive_mem();
        int w;
        w = (acc < 2) ? wt[acc] : 0;
        if (mem_read || mem_write) begin
            if (wcnt < w) begin mem_ready = 1'b0; wcnt++; end
            else begin mem_ready = 1'b1; wcnt = 0; acc++; end
        end else begin
            mem_ready = 1'b0;
        end
    endtask

    task automatic reset_dut();
        @(negedge clk);
        reset_b = 1'b0;
        mem_ready = 1'b0;
        #1;
        chk("rst_mem_read", mem_read, 1);
        chk("rst_mem_write", mem_write, 0);
        chk("rst_reg_write", reg_write, 0);
        chk("rst_pc_write", pc_write, 0);
        chk("rst_ir_write", ir_write, 0);
        chk("rst_alu_src_b", alu_src_b, 1);
        chk("rst_alu_control", alu_control, 4'b0010);
        chk("rst_retire_count", retire_count, 0);
        chk("rst_halted", halted, 0);
        repeat (2) @(negedge clk);
        #1 chk("rst_hold_mem_read", mem_read, 1);
        q.delete();
        model_cnt = 0;
        @(negedge clk);
        #3 reset_b = 1'b1;
    endtask

    task automatic run_instr(input logic [31:0] i, input bit z, input bit s,
                             input int fw, input int mw);
        exp_t e;
        bit done;
        done = 0;
        e = model(i, z, s, fw, mw);
        wt[0] = fw; wt[1] = mw; acc = 0; wcnt = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (c == 0) begin
                ir = i; alu_zero = z; alu_sign = s;
                e.cnt = model_cnt % (1 << CW);
                q.push_back(e);
                model_cnt++;
            end
            drive_mem();
            #1;
            if (inst_retired) begin done = 1; break; end
        end
        if (!done) begin
            tests++; fails++;
            $display("FAIL timeout ir=%h: no retirement within 40 cycles", i);
            reset_dut();
        end
    endtask

    task automatic run_random();
        int k, f3i, f3;
        logic [31:0] i;
        int f3tab[7] = '{0, 1, 2, 4, 5, 6, 7};
        k = $urandom_range(0, 4);
        f3i = $urandom_range(0, 6);
        i = $urandom;
        case (k)
            0: begin i[6:0] = 7'b0110011; i[14:12] = 3'(f3tab[f3i]); i[31:25] = {1'b0, $urandom_range(0, 1) == 1, 5'b0}; end
            1: begin i[6:0] = 7'b0010011; i[14:12] = 3'(f3tab[f3i]); end
            2: begin i[6:0] = 7'b0000011; i[14:12] = 3'b010; end
            3: begin i[6:0] = 7'b0100011; i[14:12] = 3'b010; end
            default: begin f3 = $urandom_range(0, 7); i[6:0] = 7'b1100011; i[14:12] = 3'(f3); end
        endcase
        run_instr(i, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 2), $urandom_range(0, 2));
    endtask

    // Monitor: accumulate what the controller did since the last retirement, check on retire.
    initial begin : monitor
        int cyc, regw, memw, pcw, pcw1;
        logic m2r;
        logic [3:0] aluc;
        exp_t e;
        cyc = 0; regw = 0; memw = 0; pcw = 0; pcw1 = 0; m2r = 0; aluc = 4'hx;
        forever begin
            @(negedge clk);
            #2;
            if (!reset_b) begin
                cyc = 0; regw = 0; memw = 0; pcw = 0; pcw1 = 0; m2r = 0; aluc = 4'hx;
            end else begin
                cyc++;
                if (reg_write) begin regw++; m2r = mem_to_reg; end
                if (mem_write) memw++;
                if (pc_write) begin pcw++; if (pc_src) pcw1++; end
                if (alu_src_a == 2'd2) aluc = alu_control;
                if (mem_read && mem_write) chk("rd_wr_exclusive", 1, 0);
                if (inst_retired) begin
                    if (q.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL unexpected_retire: got retirement, expected none");
                    end else begin
                        e = q.pop_front();
                        chk("cycles", cyc, e.cycles);
                        chk("reg_write_cnt", regw, e.regw);
                        chk("mem_to_reg", m2r, e.m2r);
                        chk("mem_write_cnt", memw, e.memw);
                        chk("pc_write_cnt", pcw, e.pcw);
                        chk("pc_src1_cnt", pcw1, e.pcw_src1);
                        chk("alu_control", aluc, e.aluc);
                        chk("retire_count", retire_count, e.cnt);
                    end
                    cyc = 0; regw = 0; memw = 0; pcw = 0; pcw1 = 0; m2r = 0; aluc = 4'hx;
                end
            end
        end
    end

    initial begin : stim
        bit wr_seen;
        bit aborted;
        reset_dut();

        run_instr(32'h40208133, 0, 0, 0, 0);   // sub x2,x1,x2
        run_instr(32'h0000A103, 0, 0, 0, 2);   // lw with two memory wait cycles
        run_instr(32'h00208463, 1, 0, 0, 0);   // beq taken
        run_instr(32'h00208463, 0, 0, 0, 0);   // beq not taken
        run_instr(32'h0020A023, 0, 0, 1, 1);   // sw with waits
        run_instr(32'h4050D093, 0, 0, 0, 0);   // srai
        run_instr(32'h40008093, 0, 0, 0, 0);   // addi with imm bit 30 set

        repeat (60) run_random();

        // Illegal opcode: halts after decode, nothing written, nothing retired.
        @(negedge clk);
        ir = 32'h0000007F; wt[0] = 0; wt[1] = 0; acc = 0; wcnt = 0; wr_seen = 0;
        for (int c = 0; c < 10; c++) begin
            if (c != 0) @(negedge clk);
            drive_mem();
            #1;
            if (reg_write || mem_write) wr_seen = 1;
            if (halted) break;
        end
        chk("halt_reached", halted, 1);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            chk("halt_sticky", halted, 1);
            chk("halt_no_enables", {pc_write, ir_write, reg_write, mem_write, mem_read, inst_retired}, 0);
            chk("halt_count", retire_count, model_cnt % (1 << CW));
        end
        chk("halt_no_writes", wr_seen, 0);

        reset_dut();
        run_instr(32'h002081B3, 0, 0, 0, 0);   // add
        run_instr(32'h00209463, 0, 0, 0, 0);   // bne taken

        // Reset while a store waits on memory.
        @(negedge clk);
        ir = 32'h0020A023; wt[0] = 0; wt[1] = 10; acc = 0; wcnt = 0; aborted = 0;
        for (int c = 0; c < 20; c++) begin
            if (c != 0) @(negedge clk);
            drive_mem();
            if (mem_write && wcnt >= 2) begin aborted = 1; break; end
        end
        chk("abort_reached_mem_wr", aborted, 1);
        #1 reset_b = 1'b0;
        #1;
        chk("abort_mem_write", mem_write, 0);
        chk("abort_mem_read", mem_read, 1);
        chk("abort_reg_write", reg_write, 0);
        chk("abort_retire_count", retire_count, 0);
        @(posedge clk);
        #1;
        chk("abort_fetch_mem_read", mem_read, 1);
        chk("abort_fetch_src_b", alu_src_b, 1);
        q.delete();
        model_cnt = 0;
        @(negedge clk);
        #3 reset_b = 1'b1;

        repeat (4) run_random();

        @(negedge clk);
        #3 chk("scoreboard_empty", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
